// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request and write-back signal bundle for muldiv_unit
interface muldiv_unit_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        we_out;

   modport master (
      output start, funct3, rs1_val, rs2_val, rd_in,
      input  busy, done, result, rd_out, we_out
   );

   modport slave (
      input  start, funct3, rs1_val, rs2_val, rd_in,
      output busy, done, result, rd_out, we_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M iterative multiply/divide unit, 32 cycles per op
// Define MULDIV_DIV_EN to build the restoring divider and its bypass cases.
module muldiv_unit (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic [1:0]  r_op;
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic        r_neg;
   logic [63:0] r_acc;
   logic [63:0] r_mcand;
   logic [31:0] r_mplier;

   logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic [63:0] w_acc_next, w_prod;
   logic        w_last;

   // Divide ops are signed when funct3[0]=0; multiply ops per RV32M sign rules
   assign w_a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
   assign w_b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
   assign w_a_neg    = w_a_signed & bus.rs1_val[31];
   assign w_b_neg    = w_b_signed & bus.rs2_val[31];
   assign w_a_mag    = w_a_neg ? -bus.rs1_val : bus.rs1_val;
   assign w_b_mag    = w_b_neg ? -bus.rs2_val : bus.rs2_val;

   assign w_last     = (r_cnt == 5'd31);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
   assign w_prod     = r_neg ? -w_acc_next : w_acc_next;

`ifdef MULDIV_DIV_EN
   logic        r_rneg;
   logic [31:0] r_quo, r_rem, r_div;
   logic        w_div0, w_ovf, w_bypass, w_ge;
   logic [31:0] w_bypass_val, w_sub, w_rem_next, w_quo_next, w_q_fix, w_r_fix;
   logic [32:0] w_rem_sh;

   assign w_div0       = (bus.rs2_val == 32'd0);
   assign w_ovf        = ~bus.funct3[0] & (bus.rs1_val == 32'h8000_0000) &
                         (bus.rs2_val == 32'hFFFF_FFFF);
   assign w_bypass     = w_div0 | w_ovf;
   assign w_bypass_val = w_div0 ? (bus.funct3[1] ? bus.rs1_val : 32'hFFFF_FFFF)
                                : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);

   // A successful subtract always leaves rem < divisor, so 32 bits suffice
   assign w_rem_sh   = {r_rem, r_quo[31]};
   assign w_ge       = (w_rem_sh >= {1'b0, r_div});
   assign w_sub      = w_rem_sh[31:0] - r_div;
   assign w_rem_next = w_ge ? w_sub : w_rem_sh[31:0];
   assign w_quo_next = {r_quo[30:0], w_ge};
   assign w_q_fix    = r_neg  ? -w_quo_next : w_quo_next;
   assign w_r_fix    = r_rneg ? -w_rem_next : w_rem_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               if (!bus.funct3[2])  w_next = MUL;
`ifdef MULDIV_DIV_EN
               else if (w_bypass)   w_next = DONE;
               else                 w_next = DIV;
`else
               else                 w_next = DONE;
`endif
            end
         end
         MUL:     if (w_last) w_next = DONE;
         DIV:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= 5'd0;
         r_op     <= 2'd0;
         r_rd     <= 5'd0;
         r_result <= 32'd0;
         r_neg    <= 1'b0;
         r_acc    <= 64'd0;
         r_mcand  <= 64'd0;
         r_mplier <= 32'd0;
`ifdef MULDIV_DIV_EN
         r_rneg   <= 1'b0;
         r_quo    <= 32'd0;
         r_rem    <= 32'd0;
         r_div    <= 32'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_cnt    <= 5'd0;
                  r_op     <= bus.funct3[1:0];
                  r_rd     <= bus.rd_in;
                  r_neg    <= w_a_neg ^ w_b_neg;
                  r_acc    <= 64'd0;
                  r_mcand  <= {32'd0, w_a_mag};
                  r_mplier <= w_b_mag;
`ifdef MULDIV_DIV_EN
                  r_rneg   <= w_a_neg;
                  r_quo    <= w_a_mag;
                  r_rem    <= 32'd0;
                  r_div    <= w_b_mag;
                  if (bus.funct3[2] && w_bypass) r_result <= w_bypass_val;
`else
                  if (bus.funct3[2]) r_result <= 32'd0;
`endif
               end
            end
            MUL: begin
               r_cnt    <= r_cnt + 5'd1;
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (w_last) r_result <= (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
               r_cnt <= r_cnt + 5'd1;
               r_quo <= w_quo_next;
               r_rem <= w_rem_next;
               if (w_last) r_result <= r_op[1] ? w_r_fix : w_q_fix;
            end
`endif
            default: ;
         endcase
      end
   end

   // Reset forces the status outputs low even before the state register clears
   assign bus.busy   = (r_state != IDLE) & ~rst;
   assign bus.done   = (r_state == DONE) & ~rst;
   assign bus.we_out = bus.done & (r_rd != 5'd0);
   assign bus.result = r_result;
   assign bus.rd_out = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
   logic clk;
   logic rst;
   muldiv_unit_if bus ();

   muldiv_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb_s, ub;
      logic        [63:0] p;
      logic signed [31:0] x, y;
      sa   = {{32{a[31]}}, a};
      sb_s = {{32{b[31]}}, b};
      ub   = {32'd0, b};
      x    = a;
      y    = b;
      case (f)
         3'd0: begin p = sa * sb_s;            return p[31:0];  end
         3'd1: begin p = sa * sb_s;            return p[63:32]; end
         3'd2: begin p = sa * ub;              return p[63:32]; end
         3'd3: begin p = {32'd0, a} * ub;      return p[63:32]; end
`ifdef MULDIV_DIV_EN
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return x / y;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return x % y;
         end
         default: return (b == 0) ? a : a % b;
`else
         default: return 32'd0;
`endif
      endcase
   endfunction

   function automatic int model_cyc(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
      if (!f[2]) return 33;
`ifdef MULDIV_DIV_EN
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
`else
      return 1;
`endif
   endfunction

   // Issues one op, then checks the write-back against the scoreboard head
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] got);
      exp_t e;
      int   cyc;
      e.result = model(f, a, b);
      e.rd     = rd;
      e.we     = (rd != 5'd0);
      e.cyc    = model_cyc(f, a, b);
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = f; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.rd_in = 5'd31;
      check("busy_first", {31'd0, bus.busy}, 32'd1);
      cyc = 1;
      while (!bus.done && cyc < 60) begin
         if (cyc == 5) begin bus.start = 1'b1; bus.funct3 = ~f; end
         @(posedge clk); #1;
         bus.start = 1'b0;
         cyc++;
      end
      e = sb.pop_front();
      got = bus.result;
      check("done_cycle", cyc, e.cyc);
      check("result", bus.result, e.result);
      check("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
      check("we_out", {31'd0, bus.we_out}, {31'd0, e.we});
      @(posedge clk); #1;
      check("idle_busy", {31'd0, bus.busy | bus.done}, 32'd0);
      check("hold_result", bus.result, e.result);
   endtask

   logic [31:0] got;
   int          pulses;

   initial begin
      bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1_val = 32'd0; bus.rs2_val = 32'd0;
      bus.rd_in = 5'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {29'd0, bus.busy, bus.done, bus.we_out}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_rd", {27'd0, bus.rd_out}, 32'd0);
      rst = 1'b0;

      run_op(3'd0, 32'd7, 32'd6, 5'd5, got);
      check("mul_7x6", got, 32'h0000_002A);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, got);
      check("mulh_m1", got, 32'h0000_0000);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, got);
      check("mulhu_max", got, 32'hFFFF_FFFE);
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, got);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, got);
      run_op(3'd0, 32'd3, 32'd3, 5'd0, got);
      check("mul_rd0", got, 32'h0000_0009);

`ifdef MULDIV_DIV_EN
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, got);
      check("div_neg7_2", got, 32'hFFFF_FFFD);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, got);
      check("rem_neg7_2", got, 32'hFFFF_FFFF);
      run_op(3'd5, 32'd5, 32'd0, 5'd8, got);
      check("divu_by0", got, 32'hFFFF_FFFF);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, got);
      check("rem_ovf", got, 32'd0);
`else
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, got);
      check("div_disabled", got, 32'd0);
      run_op(3'd5, 32'd5, 32'd0, 5'd8, got);
`endif
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, got);
      run_op(3'd7, 32'd5, 32'd0, 5'd11, got);
      run_op(3'd6, 32'd100, 32'hFFFF_FFF9, 5'd12, got);
      run_op(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd13, got);

      for (int i = 0; i < 10; i++)
         run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), got);

      // Reset in cycle 10 of a multiply must abort with no done pulse
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_val = 32'h1234; bus.rs2_val = 32'h5678;
      bus.rd_in = 5'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      pulses = 0;
      repeat (9) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      rst = 1'b1;
      #1;
      check("rst_mid_outputs", {29'd0, bus.busy, bus.done, bus.we_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_result", bus.result, 32'd0);
      check("abort_rd", {27'd0, bus.rd_out}, 32'd0);
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      check("abort_no_done", pulses, 32'd0);
      run_op(3'd0, 32'h1234, 32'h5678, 5'd7, got);
      check("after_abort", got, 32'h0626_0060);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
